conv_encoder: RTL

Rate-1/2 feed-forward convolutional encoder with a frame-based valid/ready stream interface. It is the transmit-side counterpart of the Viterbi decoder datapath. It produces the 2-bit code symbols that the decoder's branch-metric and add-compare-select units consume. It also terminates each frame with K-1 zero tail bits, so every frame ends in trellis state 0, the start state the decoder's traceback assumes.

---
 rtl/viterbi_pkg.sv | 20 ++
 rtl/conv_sym_gen.sv | 21 ++
 rtl/conv_encoder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared definitions for the convolutional encoder and the Viterbi decoder.
//   VIT_K, VIT_G0, VIT_G1 : default constraint length and generator polynomials
//   enc_state_e           : encoder frame FSM states
//   parity                : XOR-reduction helper for generator taps
package viterbi_pkg;

  localparam int unsigned      VIT_K  = 3;
  localparam logic [VIT_K-1:0] VIT_G0 = 3'b111;
  localparam logic [VIT_K-1:0] VIT_G1 = 3'b101;

  typedef enum logic {
    S_DATA = 1'b0,
    S_TAIL = 1'b1
  } enc_state_e;

  function automatic logic parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/conv_sym_gen.sv
// Combinational code-symbol generator, shared with the decoder's branch-symbol logic.
//   w   : encoding word {current bit, shift register}, MSB = current bit
//   sym : [1] = G0 parity, [0] = G1 parity
module conv_sym_gen
  import viterbi_pkg::*;
#(
  parameter int unsigned    K  = VIT_K,
  parameter logic [K-1:0]   G0 = VIT_G0,
  parameter logic [K-1:0]   G1 = VIT_G1
) (
  input  logic [K-1:0] w,
  output logic [1:0]   sym
);

  always_comb begin
    sym    = '0;
    sym[1] = parity(32'(w & G0));
    sym[0] = parity(32'(w & G1));
  end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with valid/ready streaming and
// optional K-1 zero-bit frame termination.
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_valid, i_bit, i_last    : information bit stream (i_last marks frame end)
//   o_ready                   : bit accepted this cycle when high with i_valid
//   o_valid, o_sym, o_last    : code symbol stream, held stable under backpressure
//   i_ready                   : downstream accepts the symbol this cycle
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter int unsigned  K       = VIT_K,
  parameter logic [K-1:0] G0      = VIT_G0,
  parameter logic [K-1:0] G1      = VIT_G1,
  parameter bit           TAIL_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic       i_bit,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_valid,
  output logic [1:0] o_sym,
  output logic       o_last,
  input  logic       i_ready
);

  localparam int unsigned TCW = $clog2(K);

  enc_state_e       state, state_d;
  logic [K-2:0]     sr, sr_d;
  logic [TCW-1:0]   tail_cnt, tail_cnt_d;
  logic             valid_d, last_d;
  logic [1:0]       sym_d;
  logic             slot_free;
  logic             cur_bit;
  logic [1:0]       sym;

  assign slot_free = !o_valid || i_ready;
  assign o_ready   = (state == S_DATA) && slot_free;
  // Tail symbols are generated from a forced-zero input bit.
  assign cur_bit   = (state == S_TAIL) ? 1'b0 : i_bit;

  conv_sym_gen #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_sym_gen (
    .w   ({cur_bit, sr}),
    .sym (sym)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_DATA;
      sr       <= '0;
      tail_cnt <= '0;
      o_valid  <= 1'b0;
      o_sym    <= '0;
      o_last   <= 1'b0;
    end else begin
      state    <= state_d;
      sr       <= sr_d;
      tail_cnt <= tail_cnt_d;
      o_valid  <= valid_d;
      o_sym    <= sym_d;
      o_last   <= last_d;
    end
  end

  always_comb begin
    state_d    = state;
    sr_d       = sr;
    tail_cnt_d = tail_cnt;
    valid_d    = o_valid;
    sym_d      = o_sym;
    last_d     = o_last;

    // A free slot means the held symbol (if any) leaves this cycle.
    if (slot_free) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    unique case (state)
      S_DATA: begin
        if (i_valid && o_ready) begin
          valid_d = 1'b1;
          sym_d   = sym;
          sr_d    = {i_bit, sr[K-2:1]};
          last_d  = 1'b0;
          if (i_last) begin
            if (TAIL_EN) begin
              state_d    = S_TAIL;
              tail_cnt_d = TCW'(K - 1);
            end else begin
              last_d = 1'b1;
              sr_d   = '0;
            end
          end
        end
      end
      S_TAIL: begin
        if (slot_free) begin
          valid_d    = 1'b1;
          sym_d      = sym;
          sr_d       = {1'b0, sr[K-2:1]};
          tail_cnt_d = tail_cnt - TCW'(1);
          last_d     = 1'b0;
          if (tail_cnt == TCW'(1)) begin
            last_d  = 1'b1;
            state_d = S_DATA;
          end
        end
      end
      default: state_d = S_DATA;
    endcase
  end

endmodule
